// File: rtl/router_vcarb_rr.sv
// Per-VC ownership arbiter: each VC independently grants one requester and holds it until release.
// Define ROUTER_VCARB_RR_EN for round-robin selection; otherwise lowest requesting index wins.
module router_vcarb_rr #(
  parameter int unsigned NO_OF_REQS = 15,
  parameter int unsigned NO_OF_VCS  = 2,
  localparam int unsigned OWNW      = $clog2(NO_OF_REQS)
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NO_OF_VCS*NO_OF_REQS-1:0] Port_vc_arb_req,
  input  logic [NO_OF_VCS-1:0]            Port_vc_release,
  output logic [NO_OF_VCS*NO_OF_REQS-1:0] Port_vc_arb_grant,
  output logic [NO_OF_VCS-1:0]            Port_vc_usage,
  output logic [NO_OF_VCS*OWNW-1:0]       Port_vc_owner
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  for (genvar v = 0; v < NO_OF_VCS; v++) begin : g_vc
    logic [NO_OF_REQS-1:0] req_v;
    logic                  rel_v;
    logic [0:0]            state_q, state_d;
    logic [NO_OF_REQS-1:0] grant_q, grant_d;
    logic [OWNW-1:0]       owner_q, owner_d;
    logic                  usage_q, usage_d;
    logic [OWNW-1:0]       win;

    assign req_v = Port_vc_arb_req[v*NO_OF_REQS +: NO_OF_REQS];
    assign rel_v = Port_vc_release[v];

`ifdef ROUTER_VCARB_RR_EN
    logic [OWNW-1:0] ptr_q, ptr_d;

    // Walk offsets downward so the smallest offset from the pointer wins.
    always_comb begin : p_pick
      int unsigned idx;
      win = '0;
      idx = 0;
      for (int i = NO_OF_REQS - 1; i >= 0; i--) begin
        idx = 32'(ptr_q) + 32'(i);
        if (idx >= NO_OF_REQS) idx = idx - NO_OF_REQS;
        if (req_v[OWNW'(idx)]) win = OWNW'(idx);
      end
    end
`else
    // Downward walk leaves the lowest requesting index as the winner.
    always_comb begin : p_pick
      win = '0;
      for (int i = NO_OF_REQS - 1; i >= 0; i--) begin
        if (req_v[OWNW'(i)]) win = OWNW'(i);
      end
    end
`endif

    // Next-state and next-output logic for the IDLE/BUSY ownership FSM.
    always_comb begin : p_next
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      usage_d = usage_q;
`ifdef ROUTER_VCARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (|req_v) begin
            state_d = ST_BUSY;
            grant_d = NO_OF_REQS'(1) << win;
            owner_d = win;
            usage_d = 1'b1;
`ifdef ROUTER_VCARB_RR_EN
            ptr_d   = (win == OWNW'(NO_OF_REQS - 1)) ? '0 : win + OWNW'(1);
`endif
          end else begin
            grant_d = '0;
            owner_d = '0;
            usage_d = 1'b0;
          end
        end
        ST_BUSY: begin
          if (rel_v) begin
            state_d = ST_IDLE;
            grant_d = '0;
            owner_d = '0;
            usage_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
          owner_d = '0;
          usage_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge Clk) begin : p_state
      if (Rst) begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        owner_q <= '0;
        usage_q <= 1'b0;
`ifdef ROUTER_VCARB_RR_EN
        ptr_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        grant_q <= grant_d;
        owner_q <= owner_d;
        usage_q <= usage_d;
`ifdef ROUTER_VCARB_RR_EN
        ptr_q   <= ptr_d;
`endif
      end
    end

    assign Port_vc_arb_grant[v*NO_OF_REQS +: NO_OF_REQS] = grant_q;
    assign Port_vc_owner[v*OWNW +: OWNW]                 = owner_q;
    assign Port_vc_usage[v]                              = usage_q;
  end

endmodule

// File: tb/tb_router_vcarb_rr.sv
// Scoreboard bench for router_vcarb_rr (15 requesters, 2 VCs); expectations follow the build's
// selection mode (ROUTER_VCARB_RR_EN round-robin, otherwise fixed priority).
module tb_router_vcarb_rr;
  localparam int unsigned N = 15;
  localparam int unsigned V = 2;
`ifdef ROUTER_VCARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          Clk;
  logic          Rst;
  logic [V*N-1:0] req;
  logic [V-1:0]   rel;
  logic [V*N-1:0] grant;
  logic [V-1:0]   usage;
  logic [V*4-1:0] owner;

  typedef struct {
    string      name;
    logic [29:0] g;
    logic [7:0]  o;
    logic [1:0]  u;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  router_vcarb_rr #(.NO_OF_REQS(N), .NO_OF_VCS(V)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Port_vc_arb_req  (req),
    .Port_vc_release  (rel),
    .Port_vc_arb_grant(grant),
    .Port_vc_usage    (usage),
    .Port_vc_owner    (owner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic rs, input logic [14:0] r0, input logic [14:0] r1,
                      input logic [1:0] rl, input logic [14:0] g0, input logic [14:0] g1,
                      input logic [3:0] o0, input logic [3:0] o1);
    exp_t e;
    @(negedge Clk);
    Rst = rs;
    req = {r1, r0};
    rel = rl;
    e.name = nm;
    e.g = {g1, g0};
    e.o = {o1, o0};
    e.u = {|g1, |g0};
    sb.push_back(e);
  endtask

  // Monitor: pop one expectation per edge and compare against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (grant !== e.g) begin
          mismatched++;
          $display("FAIL %s grant: got %h want %h", e.name, grant, e.g);
        end
        compared++;
        if (owner !== e.o) begin
          mismatched++;
          $display("FAIL %s owner: got %h want %h", e.name, owner, e.o);
        end
        compared++;
        if (usage !== e.u) begin
          mismatched++;
          $display("FAIL %s usage: got %b want %b", e.name, usage, e.u);
        end
      end
    end
  end

  initial begin
    int w;
    Rst = 1'b1;
    req = '0;
    rel = '0;

    // Reset dominates requests; first clean edge grants index 0 on both VCs.
    step("rst0",      1, 15'h7FFF, 15'h7FFF, 2'b00, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("rst1",      1, 15'h7FFF, 15'h7FFF, 2'b00, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("first",     0, 15'h7FFF, 15'h7FFF, 2'b00, 15'h0001, 15'h0001, 4'd0, 4'd0);
    step("rel_both",  0, 15'h0000, 15'h0000, 2'b11, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("idle",      0, 15'h0000, 15'h0000, 2'b00, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("idle_rel",  0, 15'h0000, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);

    // Ownership held across request changes until release.
    step("g88",       0, 15'h0088, 15'h0000, 2'b00, 15'h0008, 15'h0000, 4'd3, 4'd0);
    step("hold80",    0, 15'h0080, 15'h0000, 2'b00, 15'h0008, 15'h0000, 4'd3, 4'd0);
    step("hold00",    0, 15'h0000, 15'h0000, 2'b00, 15'h0008, 15'h0000, 4'd3, 4'd0);
    step("rel88",     0, 15'h0000, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("g88_again", 0, 15'h0088, 15'h0000, 2'b00, RR ? 15'h0080 : 15'h0008, 15'h0000,
         RR ? 4'd7 : 4'd3, 4'd0);
    step("rel2",      0, 15'h0000, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);

    // Grant at the top index, then the pointer wraps to 0.
    step("g14",       0, 15'h4000, 15'h0000, 2'b00, 15'h4000, 15'h0000, 4'd14, 4'd0);
    step("rel14",     0, 15'h0000, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("wrap",      0, 15'h4001, 15'h0000, 2'b00, 15'h0001, 15'h0000, 4'd0, 4'd0);

    // Release with full requests: one idle cycle, then next winner.
    step("rel_full",  0, 15'h7FFF, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("after_rel", 0, 15'h7FFF, 15'h0000, 2'b00, RR ? 15'h0002 : 15'h0001, 15'h0000,
         RR ? 4'd1 : 4'd0, 4'd0);
    step("rel3",      0, 15'h0000, 15'h0000, 2'b01, 15'h0000, 15'h0000, 4'd0, 4'd0);

    // Same requester owns both VCs; releasing one leaves the other intact.
    step("both5",     0, 15'h0020, 15'h0020, 2'b00, 15'h0020, 15'h0020, 4'd5, 4'd5);
    step("rel_vc0",   0, 15'h0020, 15'h0020, 2'b01, 15'h0000, 15'h0020, 4'd0, 4'd5);
    step("vc1_hold",  0, 15'h0000, 15'h0020, 2'b00, 15'h0000, 15'h0020, 4'd0, 4'd5);

    // Reset mid-BUSY drops ownership and clears the pointer.
    step("vc0_g8",    0, 15'h0100, 15'h0000, 2'b00, 15'h0100, 15'h0020, 4'd8, 4'd5);
    step("rst_busy",  1, 15'h0100, 15'h0020, 2'b00, 15'h0000, 15'h0000, 4'd0, 4'd0);
    step("post_rst",  0, 15'h0006, 15'h0006, 2'b00, 15'h0002, 15'h0002, 4'd1, 4'd1);
    step("post_hold", 0, 15'h0000, 15'h0000, 2'b00, 15'h0002, 15'h0002, 4'd1, 4'd1);

    w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(posedge Clk);
      w++;
    end
    #2;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
